// File: rtl/rob_mw.sv
// Multi-wide reorder buffer: in-order allocate, out-of-order complete, in-order retire, branch squash.
// Latency: alloc visible next cycle; CDB write -> commit_valid one cycle later at the earliest.
// Backpressure: all-or-nothing alloc_accept; dispatch holds while a group does not fit or a flush is active.
//
// Ports:
//   clock, reset              posedge clock, asynchronous active-high reset
//   alloc_req/wr_mem/dest     per-lane dispatch request; alloc_accept / alloc_tags back to dispatch
//   cdb_valid/tag/value       completion write ports (higher index wins on duplicate tags)
//   read_tag -> read_value/ready   operand lookup with same-cycle CDB forwarding
//   flush_valid/flush_tag     squash every entry younger than flush_tag
//   commit_*                  per-lane retire outputs to register file / store commit
//   full, empty, free_count   occupancy status
module rob_mw #(
    parameter int ROB_SIZE       = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int CDB_PORTS      = 2,
    parameter int XLEN           = 32,
    parameter int TAG_LEN        = $clog2(ROB_SIZE),
    parameter int CNT_LEN        = $clog2(ROB_SIZE + 1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DISPATCH_WIDTH-1:0]         alloc_req,
    input  logic [DISPATCH_WIDTH-1:0]         alloc_wr_mem,
    input  logic [DISPATCH_WIDTH*5-1:0]       alloc_dest,
    output logic                              alloc_accept,
    output logic [DISPATCH_WIDTH*TAG_LEN-1:0] alloc_tags,
    input  logic [CDB_PORTS-1:0]              cdb_valid,
    input  logic [CDB_PORTS*TAG_LEN-1:0]      cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]         cdb_value,
    input  logic [TAG_LEN-1:0]                read_tag,
    output logic [XLEN-1:0]                   read_value,
    output logic                              read_ready,
    input  logic                              flush_valid,
    input  logic [TAG_LEN-1:0]                flush_tag,
    output logic [COMMIT_WIDTH-1:0]           commit_valid,
    output logic [COMMIT_WIDTH*5-1:0]         commit_dest,
    output logic [COMMIT_WIDTH*XLEN-1:0]      commit_value,
    output logic [COMMIT_WIDTH-1:0]           commit_wr_mem,
    output logic                              full,
    output logic                              empty,
    output logic [CNT_LEN-1:0]                free_count
);

    // One extra bit so free slots plus same-cycle commits cannot overflow.
    localparam int SW = CNT_LEN + 1;

    logic [ROB_SIZE-1:0]                valid_q, valid_d;
    logic [ROB_SIZE-1:0]                ready_q, ready_d;
    logic [ROB_SIZE-1:0]                wr_mem_q, wr_mem_d;
    logic [ROB_SIZE-1:0][4:0]           dest_q, dest_d;
    logic [ROB_SIZE-1:0][XLEN-1:0]      value_q, value_d;
    logic [TAG_LEN-1:0]                 head_q, head_d;
    logic [TAG_LEN-1:0]                 tail_q, tail_d;
    logic [CNT_LEN-1:0]                 count_q, count_d;

    logic [SW-1:0]                      commit_cnt;
    logic [SW-1:0]                      alloc_n;
    logic [SW-1:0]                      avail;
    logic                               flush_hit;
    logic [TAG_LEN-1:0]                 flush_age;

    assign full       = (count_q == CNT_LEN'(ROB_SIZE));
    assign empty      = (count_q == '0);
    assign free_count = CNT_LEN'(ROB_SIZE) - count_q;

    // Flush position measured as age from head, so wrap-around needs no special case.
    assign flush_hit  = flush_valid && valid_q[flush_tag];
    assign flush_age  = flush_tag - head_q;

    // Commit group: contiguous ready entries from head; a store only retires from lane 0
    // and always closes the group, so at most one store leaves per cycle.
    always_comb begin
        logic [TAG_LEN-1:0] cidx;
        logic               stop;
        cidx          = '0;
        stop          = 1'b0;
        commit_valid  = '0;
        commit_dest   = '0;
        commit_value  = '0;
        commit_wr_mem = '0;
        commit_cnt    = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            cidx = head_q + TAG_LEN'(j);
            if (!stop && valid_q[cidx] && ready_q[cidx] && (j == 0 || !wr_mem_q[cidx])) begin
                commit_valid[j]               = 1'b1;
                commit_dest[j*5 +: 5]         = dest_q[cidx];
                commit_value[j*XLEN +: XLEN]  = value_q[cidx];
                commit_wr_mem[j]              = wr_mem_q[cidx];
                commit_cnt                    = commit_cnt + SW'(1);
                if (wr_mem_q[cidx]) begin
                    stop = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Allocation: slots freed by this cycle's commit count as available.
    always_comb begin
        alloc_n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_n = alloc_n + SW'(alloc_req[i]);
        end
        avail        = SW'(free_count) + commit_cnt;
        alloc_accept = !flush_valid && (alloc_n != '0) && (alloc_n <= avail);
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_tags[i*TAG_LEN +: TAG_LEN] = tail_q + TAG_LEN'(i);
        end
    end

    // Operand read with CDB bypass; later ports override earlier ones.
    always_comb begin
        read_value = value_q[read_tag];
        read_ready = ready_q[read_tag];
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_LEN +: TAG_LEN] == read_tag)) begin
                read_value = cdb_value[p*XLEN +: XLEN];
                read_ready = 1'b1;
            end
        end
    end

    // Next state. Order matters: retire, squash, CDB (only into entries still live
    // after retire/squash), then allocation, which may reuse a just-retired slot.
    always_comb begin
        logic [TAG_LEN-1:0] idx;
        logic [TAG_LEN-1:0] age;
        idx      = '0;
        age      = '0;
        valid_d  = valid_q;
        ready_d  = ready_q;
        wr_mem_d = wr_mem_q;
        dest_d   = dest_q;
        value_d  = value_q;
        head_d   = head_q + TAG_LEN'(commit_cnt);
        tail_d   = tail_q;
        count_d  = count_q;

        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            idx = head_q + TAG_LEN'(j);
            if (commit_valid[j]) begin
                valid_d[idx] = 1'b0;
            end
        end

        if (flush_hit) begin
            for (int k = 0; k < ROB_SIZE; k++) begin
                age = TAG_LEN'(k) - head_q;
                if (age > flush_age) begin
                    valid_d[k] = 1'b0;
                end
            end
        end

        for (int p = 0; p < CDB_PORTS; p++) begin
            idx = cdb_tag[p*TAG_LEN +: TAG_LEN];
            if (cdb_valid[p] && valid_d[idx]) begin
                ready_d[idx] = 1'b1;
                value_d[idx] = cdb_value[p*XLEN +: XLEN];
            end
        end

        if (alloc_accept) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                idx = tail_q + TAG_LEN'(i);
                if (alloc_req[i]) begin
                    valid_d[idx]  = 1'b1;
                    ready_d[idx]  = 1'b0;
                    wr_mem_d[idx] = alloc_wr_mem[i];
                    dest_d[idx]   = alloc_dest[i*5 +: 5];
                end
            end
            tail_d = tail_q + TAG_LEN'(alloc_n);
        end

        if (flush_hit) begin
            // The flushed branch itself survives; commits this cycle only retire entries up to it.
            tail_d  = flush_tag + TAG_LEN'(1);
            count_d = CNT_LEN'(SW'(flush_age) + SW'(1) - commit_cnt);
        end else begin
            count_d = CNT_LEN'(SW'(count_q) - commit_cnt + (alloc_accept ? alloc_n : '0));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            ready_q  <= '0;
            wr_mem_q <= '0;
            dest_q   <= '0;
            value_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            wr_mem_q <= wr_mem_d;
            dest_q   <= dest_d;
            value_q  <= value_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_mw.sv
// Directed bench for rob_mw with default parameters (8 entries, 2-wide everywhere).
// Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later.
// Every expected value below is hand-derived from the reorder-buffer behaviour.
module tb_rob_mw;

    localparam int RS = 8;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int CP = 2;
    localparam int XL = 32;
    localparam int TL = 3;
    localparam int CL = 4;

    logic               clock;
    logic               reset;
    logic [DW-1:0]      alloc_req;
    logic [DW-1:0]      alloc_wr_mem;
    logic [DW*5-1:0]    alloc_dest;
    logic               alloc_accept;
    logic [DW*TL-1:0]   alloc_tags;
    logic [CP-1:0]      cdb_valid;
    logic [CP*TL-1:0]   cdb_tag;
    logic [CP*XL-1:0]   cdb_value;
    logic [TL-1:0]      read_tag;
    logic [XL-1:0]      read_value;
    logic               read_ready;
    logic               flush_valid;
    logic [TL-1:0]      flush_tag;
    logic [CW-1:0]      commit_valid;
    logic [CW*5-1:0]    commit_dest;
    logic [CW*XL-1:0]   commit_value;
    logic [CW-1:0]      commit_wr_mem;
    logic               full;
    logic               empty;
    logic [CL-1:0]      free_count;

    int n_checks = 0;
    int n_pass   = 0;

    rob_mw #(
        .ROB_SIZE(RS), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .CDB_PORTS(CP), .XLEN(XL)
    ) dut (
        .clock(clock), .reset(reset),
        .alloc_req(alloc_req), .alloc_wr_mem(alloc_wr_mem), .alloc_dest(alloc_dest),
        .alloc_accept(alloc_accept), .alloc_tags(alloc_tags),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .read_tag(read_tag), .read_value(read_value), .read_ready(read_ready),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .commit_valid(commit_valid), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_wr_mem(commit_wr_mem),
        .full(full), .empty(empty), .free_count(free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        alloc_req    = '0;
        alloc_wr_mem = '0;
        alloc_dest   = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        cdb_value    = '0;
        read_tag     = '0;
        flush_valid  = 1'b0;
        flush_tag    = '0;
    endtask

    task automatic alloc(input logic [1:0] req, input logic [1:0] wm,
                         input logic [4:0] d0, input logic [4:0] d1);
        alloc_req    = req;
        alloc_wr_mem = wm;
        alloc_dest   = {d1, d0};
    endtask

    task automatic cdb(input int port, input logic [TL-1:0] tag, input logic [XL-1:0] val);
        cdb_valid[port]            = 1'b1;
        cdb_tag[port*TL +: TL]     = tag;
        cdb_value[port*XL +: XL]   = val;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #12;
        // Reset defaults
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_free", 64'(free_count), 64'd8);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_alloc_accept", 64'(alloc_accept), 64'd0);
        chk("rst_alloc_tags", 64'(alloc_tags), 64'h08);   // lane1=1, lane0=0
        reset = 1'b0;

        // Basic alloc / complete / commit
        idle(); alloc(2'b11, 2'b00, 5'd3, 5'd4); #1;
        chk("a1_accept", 64'(alloc_accept), 64'd1);
        chk("a1_tags", 64'(alloc_tags), 64'h08);
        cyc();
        idle(); cdb(0, 3'd0, 32'd5); cdb(1, 3'd1, 32'd7); read_tag = 3'd1; #1;
        chk("a1_no_commit_yet", 64'(commit_valid), 64'd0);
        chk("a1_free", 64'(free_count), 64'd6);
        chk("fwd_value", 64'(read_value), 64'd7);
        chk("fwd_ready", 64'(read_ready), 64'd1);
        cyc();
        idle(); #1;
        chk("a1_commit_valid", 64'(commit_valid), 64'd3);
        chk("a1_commit_value", 64'(commit_value), {32'd7, 32'd5});
        chk("a1_commit_dest", 64'(commit_dest), 64'({5'd4, 5'd3}));
        chk("a1_commit_wr_mem", 64'(commit_wr_mem), 64'd0);
        cyc();

        // Out-of-order completion, head=2
        idle(); alloc(2'b11, 2'b00, 5'd6, 5'd7); #1;
        chk("a2_empty", 64'(empty), 64'd1);
        chk("a2_free", 64'(free_count), 64'd8);
        chk("a2_tags", 64'(alloc_tags), 64'h1a);          // lane1=3, lane0=2
        cyc();
        idle(); cdb(0, 3'd3, 32'd9); read_tag = 3'd3; #1;
        chk("ooo_fwd_value", 64'(read_value), 64'd9);
        chk("ooo_fwd_ready", 64'(read_ready), 64'd1);
        cyc();
        idle(); cdb(1, 3'd2, 32'd1); read_tag = 3'd3; #1;
        chk("ooo_hold", 64'(commit_valid), 64'd0);
        chk("ooo_stored_value", 64'(read_value), 64'd9);
        chk("ooo_stored_ready", 64'(read_ready), 64'd1);
        cyc();
        idle(); #1;
        chk("ooo_commit_valid", 64'(commit_valid), 64'd3);
        chk("ooo_commit_value", 64'(commit_value), {32'd9, 32'd1});
        cyc();

        // Two ready stores retire one per cycle, head=4
        idle(); alloc(2'b11, 2'b11, 5'd1, 5'd2); #1;
        chk("st_tags", 64'(alloc_tags), 64'h2c);          // lane1=5, lane0=4
        cyc();
        idle(); cdb(0, 3'd4, 32'h0a); cdb(1, 3'd5, 32'h0b); cyc();
        idle(); #1;
        chk("st1_commit_valid", 64'(commit_valid), 64'd1);
        chk("st1_wr_mem", 64'(commit_wr_mem), 64'd1);
        chk("st1_value", 64'(commit_value[31:0]), 64'h0a);
        cyc();
        idle(); #1;
        chk("st2_commit_valid", 64'(commit_valid), 64'd1);
        chk("st2_wr_mem", 64'(commit_wr_mem), 64'd1);
        chk("st2_value", 64'(commit_value[31:0]), 64'h0b);
        cyc();

        // Single entry at 6 so the fill starts at tail=7
        idle(); alloc(2'b01, 2'b00, 5'd9, 5'd0); cyc();
        idle(); cdb(0, 3'd6, 32'h42); cyc();
        idle(); #1;
        chk("s6_commit_valid", 64'(commit_valid), 64'd1);
        chk("s6_value", 64'(commit_value[31:0]), 64'h42);
        chk("s6_dest", 64'(commit_dest[4:0]), 64'd9);
        cyc();

        // Fill: 4 dual allocs, first straddles 7 -> 0
        idle(); alloc(2'b11, 2'b00, 5'd11, 5'd12); #1;
        chk("fill_wrap_tags", 64'(alloc_tags), 64'h07);   // lane1=0, lane0=7
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle(); alloc(2'b11, 2'b00, 5'd13, 5'd14); cyc();
        end
        idle(); alloc(2'b01, 2'b00, 5'd15, 5'd0); cdb(0, 3'd7, 32'h77); #1;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_free", 64'(free_count), 64'd0);
        chk("full_reject", 64'(alloc_accept), 64'd0);
        cyc();
        idle(); alloc(2'b01, 2'b00, 5'd15, 5'd0); #1;
        chk("full_commit_valid", 64'(commit_valid), 64'd1);
        chk("full_reuse_accept", 64'(alloc_accept), 64'd1);
        chk("full_reuse_tag", 64'(alloc_tags[2:0]), 64'd7);
        cyc();
        idle(); #1;
        chk("still_full", 64'(full), 64'd1);
        chk("tail_wrapped", 64'(alloc_tags), 64'h08);
        // Reset while full: takes effect without a clock edge
        reset = 1'b1; #1;
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_free", 64'(free_count), 64'd8);
        chk("midrst_commit", 64'(commit_valid), 64'd0);
        reset = 1'b0;
        cyc();

        // Flush: 6 live entries (0..5), flush_tag=1
        for (int i = 0; i < 3; i++) begin
            idle(); alloc(2'b11, 2'b00, 5'd20, 5'd21); cyc();
        end
        idle(); alloc(2'b11, 2'b00, 5'd22, 5'd23);
        flush_valid = 1'b1; flush_tag = 3'd1;
        cdb(0, 3'd0, 32'h55); cdb(1, 3'd3, 32'h33); #1;
        chk("fl_free_before", 64'(free_count), 64'd2);
        chk("fl_blocks_alloc", 64'(alloc_accept), 64'd0);
        cyc();
        idle(); read_tag = 3'd3; #1;
        chk("fl_free_after", 64'(free_count), 64'd6);
        chk("fl_tail", 64'(alloc_tags), 64'h1a);          // tail = 2
        chk("fl_commit_valid", 64'(commit_valid), 64'd1);
        chk("fl_commit_value", 64'(commit_value[31:0]), 64'h55);
        chk("fl_squashed_cdb_dropped", 64'(read_ready), 64'd0);
        cyc();
        idle(); cdb(0, 3'd4, 32'h99); #1;
        chk("fl_free_post_commit", 64'(free_count), 64'd7);
        cyc();
        idle(); read_tag = 3'd4; cdb(0, 3'd1, 32'h22); cdb(1, 3'd1, 32'h11); #1;
        chk("late_cdb_squashed", 64'(read_ready), 64'd0);
        chk("br_not_ready", 64'(commit_valid), 64'd0);
        read_tag = 3'd1; #1;
        chk("dup_fwd_high_port", 64'(read_value), 64'h11);
        cyc();
        idle(); #1;
        chk("br_commit_valid", 64'(commit_valid), 64'd1);
        chk("br_dup_high_port", 64'(commit_value[31:0]), 64'h11);
        cyc();
        idle(); #1;
        chk("final_empty", 64'(empty), 64'd1);
        chk("final_free", 64'(free_count), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rob_mw.md
Name: rob_mw

Overview:
- Multi-wide reorder buffer for the out-of-order core.
- Allocates up to DISPATCH_WIDTH entries per cycle and absorbs CDB_PORTS completions per cycle.
- Retires up to COMMIT_WIDTH ready entries in program order.
- Squashes younger entries on branch mispredict. Sits between dispatch, the CDB and the architectural register file / store commit path.

Parameters:
- ROB_SIZE, 8, number of entries; power of two, at least 2.
- DISPATCH_WIDTH, 2, allocation lanes per cycle.
- COMMIT_WIDTH, 2, retire lanes per cycle.
- CDB_PORTS, 2, completion write ports per cycle.
- XLEN, 32, data width.
- TAG_LEN, $clog2(ROB_SIZE), derived; entry tag width.
- CNT_LEN, $clog2(ROB_SIZE+1), derived; occupancy counter width.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high.
- alloc_req  in  DISPATCH_WIDTH  lane-i allocation request; lanes contiguous from lane 0.
- alloc_wr_mem  in  DISPATCH_WIDTH  lane-i instruction is a store.
- alloc_dest  in  DISPATCH_WIDTH*5  lane-i destination register.
- alloc_accept  out  1  all requested lanes accepted this cycle.
- alloc_tags  out  DISPATCH_WIDTH*TAG_LEN  tag for lane i = tail+i mod ROB_SIZE.
- cdb_valid  in  CDB_PORTS  completion valid per port.
- cdb_tag  in  CDB_PORTS*TAG_LEN  completing entry.
- cdb_value  in  CDB_PORTS*XLEN  result value.
- read_tag  in  TAG_LEN  operand lookup tag.
- read_value  out  XLEN  value of entry read_tag, CDB-forwarded.
- read_ready  out  1  entry read_tag holds a valid result, or a CDB port delivers it this cycle.
- flush_valid  in  1  mispredict squash request.
- flush_tag  in  TAG_LEN  mispredicted branch; every entry strictly younger is squashed.
- commit_valid  out  COMMIT_WIDTH  lane j retires this cycle.
- commit_dest  out  COMMIT_WIDTH*5  destination register per lane.
- commit_value  out  COMMIT_WIDTH*XLEN  result per lane.
- commit_wr_mem  out  COMMIT_WIDTH  retiring store per lane.
- full  out  1  count == ROB_SIZE.
- empty  out  1  count == 0.
- free_count  out  CNT_LEN  ROB_SIZE - count.

Behaviour:
- State:
  - per-entry valid, ready, wr_mem, dest, value;
  - head and tail pointers, TAG_LEN bits, wrapping modulo ROB_SIZE;
  - count register, which disambiguates full from empty.
- Reset (async):
  - head = tail = count = 0; all entry valid/ready = 0; all commit_valid = 0.
  - full = 0, empty = 1, free_count = ROB_SIZE, alloc_accept = 0 (no request present), alloc_tags lane i = i.
- Commit (combinational from registered state):
  - Lane j is valid iff entry head+j is valid and ready, and lanes 0..j-1 are valid.
  - At most one store per cycle: a store in lane j>0 ends the group, and that store waits until it reaches lane 0.
  - At the posedge, committed entries are invalidated, head advances, and count decreases.
- Allocation:
  - N = popcount(alloc_req).
  - alloc_accept = (N <= free_count + commit count). Slots freed by this cycle's commit are reusable in the same cycle.
  - All-or-nothing: if not accepted, no lane is written and dispatch holds.
  - Accepted lanes write valid=1, ready=0, wr_mem, dest; tail += N.
  - A new entry is visible the next cycle.
- CDB:
  - Each valid port sets ready=1 and writes value for its tag at the posedge, only if that entry is valid.
  - Writes to invalid or squashed entries are ignored.
  - Completion latency: CDB in cycle c -> commit_valid in cycle c+1 at the earliest.
  - Duplicate tags on two ports in one cycle: the higher port index wins.
- Read port: if a CDB port matches read_tag this cycle, its value is forwarded (highest port wins). Otherwise the stored value is returned, with read_ready = stored ready.
- Flush:
  - If flush_valid and entry flush_tag is valid, every entry from flush_tag+1 to tail-1 is invalidated.
  - tail = flush_tag+1; count is recomputed as the distance from post-commit head to the new tail.
  - Flush has priority over allocation: alloc_accept = 0 while flush_valid.
  - Same-cycle commit still retires older entries, including the flush_tag entry itself.
  - CDB writes in the flush cycle to squashed tags are dropped.
  - A flush with an invalid flush_tag is ignored.
- Wrap-around: all pointer and tag arithmetic is modulo ROB_SIZE; commit groups and alloc groups may straddle index ROB_SIZE-1 -> 0.
- Reset mid-operation: all state returns to reset values immediately. In-flight CDB data and commits are discarded.

Test Plan:
- Reset, defaults (ROB_SIZE=8, DISPATCH_WIDTH=2, COMMIT_WIDTH=2, CDB_PORTS=2) -> full=0, empty=1, free_count=8, commit_valid=00, alloc_tags lanes {0,1}.
- Alloc dest 3,4 (tags 0,1); next cycle CDB {tag0=5, tag1=7} -> following cycle commit_valid=11, commit_value 5,7, commit_dest 3,4; next cycle empty=1, free_count=8.
- Out-of-order completion:
  - Alloc tags 2,3; CDB tag3=9 only -> commit_valid=00, read_tag=3 gives read_value=9, read_ready=1.
  - Then CDB tag2=1 -> both retire in one cycle.
- Two ready stores at head -> commit_valid=01 for two consecutive cycles, commit_wr_mem=01 each cycle.
- Fill with 4 dual allocs -> full=1.
  - Alloc of 1 lane with head not ready -> alloc_accept=0.
  - With head ready: 1-lane alloc -> alloc_accept=1, full stays 1, tags wrap past 7 -> 0.
- Flush:
  - 6 live entries, flush_tag = head+1 -> count=2, tail=head+2.
  - A later CDB to a squashed tag leaves it invalid.
  - Assert reset mid-fill -> empty=1 in the same cycle.
